proc_mem_ctrl: RTL and testbench
================================

Name: proc_mem_ctrl

Overview:
- Memory-side responder for the processor core: owns instruction memory (IM) and data memory (DM) and returns im_out/dm_out for the core's pc/dar addresses.
- Commits core write strobes (dm_en, im_en) with bus data.
- Drives the core's 2-bit status through a load/run/done/error sequence.
- Provides an external preload port before execution and a DM dump port afterwards.

Parameters:
- IM_AW, 8, IM address width; depth 2^IM_AW words of 16 bits.
- DM_AW, 8, DM address width; depth 2^DM_AW bytes.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  preload write strobe, honoured in LOAD only.
- load_sel  in  1  preload target: 0 = IM, 1 = DM.
- load_addr  in  16  preload address.
- load_data  in  16  preload data; DM uses [7:0].
- load_done  in  1  preload complete; starts execution.
- restart  in  1  return from DONE or ERR to LOAD.
- pc_out  in  16  core program counter (IM read address).
- dar_out  in  16  core data address register (DM read/write address).
- bus_out  in  16  core bus (write data).
- dm_en  in  1  core DM write strobe.
- im_en  in  1  core IM write strobe.
- end_process  in  1  core halt indication.
- im_out  out  16  IM read data to core.
- dm_out  out  8  DM read data to core.
- status  out  2  00 LOAD, 01 RUN, 10 DONE, 11 ERR.
- cycle_count  out  32  clocks spent in RUN.
- dump_addr  in  DM_AW  DM readback address.
- dump_data  out  8  DM readback data.

Behaviour:
- Reset (synchronous, active-high): status = 00, im_out = 0, dm_out = 0, dump_data = 0, cycle_count = 0. Memory arrays are not cleared. Reset mid-RUN aborts execution, with no write on that edge.
- State LOAD (00):
  - load_valid writes IM[load_addr] or DM[load_addr] per load_sel.
  - Address with any bit set above the array width: write dropped, no state change.
  - load_done moves to RUN next cycle. If load_valid and load_done arrive together, the write commits first, then the state moves.
  - im_out and dm_out hold 0.
- State RUN (01):
  - Every cycle: im_out <= IM[pc_out[IM_AW-1:0]] and dm_out <= DM[dar_out[DM_AW-1:0]]. Read latency is exactly 1 clock.
  - Read during write returns old data.
  - dm_en=1: DM[dar_out] <= bus_out[7:0].
  - im_en=1: IM[dar_out] <= bus_out. This is self-modifying code support and uses the dar address.
  - dm_en and im_en both asserted: both commit.
  - A write whose address has upper bits nonzero (beyond DM_AW / IM_AW): write suppressed, state -> ERR next cycle.
  - Out-of-range reads alias (truncate) silently.
  - cycle_count increments each RUN cycle and saturates at 0xFFFFFFFF.
  - load_valid is ignored.
- end_process=1 in RUN: state -> DONE next cycle. A write in the same cycle still commits. If that write is out of range, ERR takes priority over DONE.
- State DONE (10):
  - Core strobes are ignored.
  - dump_data <= DM[dump_addr], 1-clock latency.
  - cycle_count frozen.
  - restart -> LOAD, clears cycle_count, memories retained.
- State ERR (11): same as DONE (dump allowed, count frozen). restart -> LOAD.
- Outside DONE/ERR, dump_data = 0.
- restart has no effect in LOAD or RUN.
- Priority within a cycle: reset > ERR detection > end_process > load_done.

Decomposition:
- Shared package: status encodings ST_LOAD/ST_RUN/ST_DONE/ST_ERR (2-bit), so the core and this block share one definition.
- Sub-module: one natural sub-module, ram_1w1r (parameterised width/depth; sync write, registered read, read-old-on-collision).
  - Instantiated for IM (16-bit).
  - Instantiated for DM (8-bit) with a second read port for dump; alternatively a 1w2r variant.
- FSM, write-mux (loader vs core) and range checks stay in the top.

Test Plan:
- Preload and run:
  - Stimulus: after reset, load IM[0..3]=0x1111,0x2222,0x3333,0x4444; pulse load_done; drive pc_out=2.
  - Expected: status=01 one cycle after load_done; im_out=0x3333 one clock after pc_out=2 is driven.
- DM write/read:
  - Stimulus: in RUN, dar_out=0x0010, bus_out=0xABCD, dm_en=1.
  - Expected: DM[0x10]=0xCD; next read at dar_out=0x10 gives dm_out=0xCD after 1 clock. A same-cycle read returns the prior value.
- Halt with write:
  - Stimulus: end_process=1 with dm_en=1 at dar_out=5, bus_out=0x0077.
  - Expected: status=10; dump_addr=5 -> dump_data=0x77 one clock later; cycle_count equals the RUN cycles elapsed.
- Out-of-range write:
  - Stimulus: dm_en=1 at dar_out=0x0100 with DM_AW=8.
  - Expected: status=11 next cycle; DM[0x00] unchanged.
- Reset mid-RUN:
  - Stimulus: assert reset during a dm_en write cycle.
  - Expected: write not committed; status=00, im_out=0, dm_out=0, cycle_count=0. Previously loaded IM contents still readable after a new load_done.
- Restart path:
  - Stimulus: from DONE, pulse restart, then load_done.
  - Expected: LOAD then RUN; cycle_count restarts from 0. load_valid during RUN leaves memory unchanged.

Source files
------------

// File: rtl/proc_mem_ctrl_pkg.sv
// Shared definitions for the processor memory controller and the core it serves.
// Status encodings and the address range check live here so both sides agree.
package proc_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } status_e;

    localparam int BUS_W = 16;

    // True when no address bit above the array width is set.
    function automatic logic addr_fits(input logic [BUS_W-1:0] addr, input int aw);
        return (addr >> aw) == '0;
    endfunction

endpackage

// File: rtl/proc_mem_ctrl_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// A read of the address being written returns the previous contents.
module ram_1w1r #(
    parameter int WIDTH = 8,
    parameter int AW    = 8
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic             clr,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [2**AW];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: the array has no reset so it maps onto block RAM; contents survive reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // NOTE: non-blocking assignment makes a same-edge read see the old word.
    always_ff @(posedge clock) begin
        if (clr) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/proc_mem_ctrl.sv
// Memory-side responder for the core: owns IM and DM, sequences LOAD/RUN/DONE/ERR,
// muxes loader vs core writes and offers a DM dump port once execution has stopped.
module proc_mem_ctrl
    import proc_mem_ctrl_pkg::*;
#(
    parameter int IM_AW = 8,
    parameter int DM_AW = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    input  logic             load_sel,
    input  logic [15:0]      load_addr,
    input  logic [15:0]      load_data,
    input  logic             load_done,
    input  logic             restart,
    input  logic [15:0]      pc_out,
    input  logic [15:0]      dar_out,
    input  logic [15:0]      bus_out,
    input  logic             dm_en,
    input  logic             im_en,
    input  logic             end_process,
    output logic [15:0]      im_out,
    output logic [7:0]       dm_out,
    output logic [1:0]       status,
    output logic [31:0]      cycle_count,
    input  logic [DM_AW-1:0] dump_addr,
    output logic [7:0]       dump_data
);

    status_e     state_q, state_d;
    logic [31:0] cycle_count_q;

    logic in_load, in_run, in_halt;
    logic im_fits, dm_fits, wr_err;
    logic im_we, dm_we;
    logic [IM_AW-1:0] im_waddr;
    logic [DM_AW-1:0] dm_waddr;
    logic [15:0]      im_wdata;
    logic [7:0]       dm_wdata;
    logic rd_clr, dump_clr;
    logic pc_hi_unused;

    assign in_load = (state_q == ST_LOAD);
    assign in_run  = (state_q == ST_RUN);
    assign in_halt = (state_q == ST_DONE) || (state_q == ST_ERR);

    // Reads alias silently, so the program counter's upper bits are deliberately ignored.
    assign pc_hi_unused = |pc_out[15:IM_AW];

    assign im_fits = addr_fits(dar_out, IM_AW);
    assign dm_fits = addr_fits(dar_out, DM_AW);
    assign wr_err  = in_run && ((im_en && !im_fits) || (dm_en && !dm_fits));

    // Loader owns the write ports in LOAD, the core in RUN; reset suppresses both.
    assign im_we = !reset &&
                   ((in_load && load_valid && !load_sel && addr_fits(load_addr, IM_AW)) ||
                    (in_run && im_en && im_fits));
    assign dm_we = !reset &&
                   ((in_load && load_valid && load_sel && addr_fits(load_addr, DM_AW)) ||
                    (in_run && dm_en && dm_fits));

    assign im_waddr = in_load ? load_addr[IM_AW-1:0] : dar_out[IM_AW-1:0];
    assign dm_waddr = in_load ? load_addr[DM_AW-1:0] : dar_out[DM_AW-1:0];
    assign im_wdata = in_load ? load_data : bus_out;
    assign dm_wdata = in_load ? load_data[7:0] : bus_out[7:0];

    // NOTE: defaulting every output first keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD: if (load_done) state_d = ST_RUN;
            ST_RUN: begin
                if (wr_err) begin
                    state_d = ST_ERR;
                end else if (end_process) begin
                    state_d = ST_DONE;
                end
            end
            default: if (restart) state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_LOAD;
            cycle_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == ST_LOAD) begin
                cycle_count_q <= '0;
            end else if (in_run && (cycle_count_q != '1)) begin
                cycle_count_q <= cycle_count_q + 32'd1;
            end
        end
    end

    // Core read data is zeroed on any entry into LOAD and held outside RUN.
    assign rd_clr   = reset || (state_d == ST_LOAD);
    assign dump_clr = reset || !((state_d == ST_DONE) || (state_d == ST_ERR));

    ram_1w1r #(.WIDTH(16), .AW(IM_AW)) u_im (
        .clock (clock),
        .we    (im_we),
        .waddr (im_waddr),
        .wdata (im_wdata),
        .re    (in_run),
        .clr   (rd_clr),
        .raddr (pc_out[IM_AW-1:0]),
        .rdata (im_out)
    );

    ram_1w1r #(.WIDTH(8), .AW(DM_AW)) u_dm (
        .clock (clock),
        .we    (dm_we),
        .waddr (dm_waddr),
        .wdata (dm_wdata),
        .re    (in_run),
        .clr   (rd_clr),
        .raddr (dar_out[DM_AW-1:0]),
        .rdata (dm_out)
    );

    // Mirror copy of DM giving the dump port its own read path.
    ram_1w1r #(.WIDTH(8), .AW(DM_AW)) u_dm_dump (
        .clock (clock),
        .we    (dm_we),
        .waddr (dm_waddr),
        .wdata (dm_wdata),
        .re    (in_halt),
        .clr   (dump_clr),
        .raddr (dump_addr),
        .rdata (dump_data)
    );

    assign status      = state_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_proc_mem_ctrl.sv
// Directed bench for proc_mem_ctrl: a vector table for the main flow, then
// hand-written sequences for the error, restart and reset-mid-run corners.
module tb_proc_mem_ctrl;

    localparam int IM_AW = 8;
    localparam int DM_AW = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             load_valid, load_sel, load_done, restart;
    logic [15:0]      load_addr, load_data;
    logic [15:0]      pc_out, dar_out, bus_out;
    logic             dm_en, im_en, end_process;
    logic [15:0]      im_out;
    logic [7:0]       dm_out;
    logic [1:0]       status;
    logic [31:0]      cycle_count;
    logic [DM_AW-1:0] dump_addr;
    logic [7:0]       dump_data;

    int n_checks = 0;
    int n_errors = 0;

    proc_mem_ctrl #(.IM_AW(IM_AW), .DM_AW(DM_AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_sel    (load_sel),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_done   (load_done),
        .restart     (restart),
        .pc_out      (pc_out),
        .dar_out     (dar_out),
        .bus_out     (bus_out),
        .dm_en       (dm_en),
        .im_en       (im_en),
        .end_process (end_process),
        .im_out      (im_out),
        .dm_out      (dm_out),
        .status      (status),
        .cycle_count (cycle_count),
        .dump_addr   (dump_addr),
        .dump_data   (dump_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        lv, ls;
        logic [15:0] la, ld;
        logic        ldone, rs;
        logic [15:0] pc, dar, bus;
        logic        dme, ime, endp;
        logic [7:0]  dump;
        logic [1:0]  e_st;
        logic        rd_chk;
        logic [15:0] e_im;
        logic [7:0]  e_dm, e_dump;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic lv, input logic ls, input logic [15:0] la, input logic [15:0] ld,
        input logic ldone, input logic rs,
        input logic [15:0] pc, input logic [15:0] dar, input logic [15:0] bus,
        input logic dme, input logic ime, input logic endp, input logic [7:0] dump,
        input logic [1:0] e_st, input logic rd_chk, input logic [15:0] e_im,
        input logic [7:0] e_dm, input logic [7:0] e_dump, input logic [31:0] e_cnt);
        vec_t v;
        v.lv = lv; v.ls = ls; v.la = la; v.ld = ld; v.ldone = ldone; v.rs = rs;
        v.pc = pc; v.dar = dar; v.bus = bus; v.dme = dme; v.ime = ime; v.endp = endp;
        v.dump = dump; v.e_st = e_st; v.rd_chk = rd_chk; v.e_im = e_im;
        v.e_dm = e_dm; v.e_dump = e_dump; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        load_valid = 0; load_sel = 0; load_addr = '0; load_data = '0;
        load_done = 0; restart = 0; pc_out = '0; dar_out = '0; bus_out = '0;
        dm_en = 0; im_en = 0; end_process = 0; dump_addr = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic [15:0] im,
                             input logic [7:0] dm, input logic [7:0] dd, input logic [31:0] cnt);
        check({tag, " status"}, 32'(status), 32'(st));
        check({tag, " im_out"}, 32'(im_out), 32'(im));
        check({tag, " dm_out"}, 32'(dm_out), 32'(dm));
        check({tag, " dump_data"}, 32'(dump_data), 32'(dd));
        check({tag, " cycle_count"}, cycle_count, cnt);
    endtask

    initial begin
        //            lv ls la       ld       dn rs pc       dar      bus      de ie ep dump   st rc im       dm     dump   cnt
        vecs.push_back(mk(1, 0, 16'h0000, 16'h1111, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 8'h00, 2'b00, 1, 16'h0000, 8'h00, 8'h00, 0));
        vecs.push_back(mk(1, 0, 16'h0001, 16'h2222, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 8'h00, 2'b00, 1, 16'h0000, 8'h00, 8'h00, 0));
        vecs.push_back(mk(1, 0, 16'h0002, 16'h3333, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 8'h00, 2'b00, 1, 16'h0000, 8'h00, 8'h00, 0));
        vecs.push_back(mk(1, 1, 16'h0010, 16'h0055, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 8'h00, 2'b00, 1, 16'h0000, 8'h00, 8'h00, 0));
        vecs.push_back(mk(1, 1, 16'h0005, 16'h0011, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 8'h00, 2'b00, 1, 16'h0000, 8'h00, 8'h00, 0));
        vecs.push_back(mk(1, 1, 16'h0000, 16'h0099, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 8'h00, 2'b00, 1, 16'h0000, 8'h00, 8'h00, 0));
        // out-of-range preload: dropped, must not alias onto DM[0]
        vecs.push_back(mk(1, 1, 16'h0100, 16'h00EE, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 8'h00, 2'b00, 1, 16'h0000, 8'h00, 8'h00, 0));
        // last preload together with load_done: write commits, then RUN
        vecs.push_back(mk(1, 0, 16'h0003, 16'h4444, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 8'h00, 2'b00, 1, 16'h0000, 8'h00, 8'h00, 0));
        vecs[7].e_st = 2'b01;
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0003, 16'h0000, 16'h0000, 0, 0, 0, 8'h00, 2'b01, 1, 16'h4444, 8'h99, 8'h00, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0002, 16'h0000, 16'h0000, 0, 0, 0, 8'h00, 2'b01, 1, 16'h3333, 8'h99, 8'h00, 2));
        // DM write: same-cycle read returns old 0x55, next read 0xCD
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0010, 16'hABCD, 1, 0, 0, 8'h00, 2'b01, 1, 16'h1111, 8'h55, 8'h00, 3));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0001, 16'h0010, 16'h0000, 0, 0, 0, 8'h00, 2'b01, 1, 16'h2222, 8'hCD, 8'h00, 4));
        // upper address bits on reads alias silently
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0103, 16'h0110, 16'h0000, 0, 0, 0, 8'h00, 2'b01, 1, 16'h4444, 8'hCD, 8'h00, 5));
        // self-modifying IM write via dar
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h5A5A, 0, 1, 0, 8'h00, 2'b01, 1, 16'h1111, 8'h99, 8'h00, 6));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0010, 16'h0000, 0, 0, 0, 8'h00, 2'b01, 1, 16'h5A5A, 8'hCD, 8'h00, 7));
        // halt with a committing write
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0001, 16'h0005, 16'h0077, 1, 0, 1, 8'h00, 2'b10, 1, 16'h2222, 8'h11, 8'h00, 8));
        // DONE: core strobe ignored, dump works
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0010, 16'h00FF, 1, 0, 0, 8'h05, 2'b10, 0, 16'h0000, 8'h00, 8'h77, 8));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 8'h10, 2'b10, 0, 16'h0000, 8'h00, 8'hCD, 8));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 8'h00, 2'b00, 1, 16'h0000, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 8'h00, 2'b01, 1, 16'h0000, 8'h00, 8'h00, 0));
        // load_valid during RUN is ignored
        vecs.push_back(mk(1, 1, 16'h0010, 16'h0033, 0, 0, 16'h0000, 16'h0010, 16'h0000, 0, 0, 0, 8'h00, 2'b01, 1, 16'h5A5A, 8'hCD, 8'h00, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0010, 16'h0000, 0, 0, 0, 8'h00, 2'b01, 1, 16'h5A5A, 8'hCD, 8'h00, 2));

        idle();
        reset = 1'b1;
        tick();
        tick();
        check_all("reset", 2'b00, 16'h0000, 8'h00, 8'h00, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            vec_t v;
            string tag;
            v = vecs[i];
            tag = $sformatf("vec%0d", i);
            load_valid = v.lv; load_sel = v.ls; load_addr = v.la; load_data = v.ld;
            load_done = v.ldone; restart = v.rs; pc_out = v.pc; dar_out = v.dar;
            bus_out = v.bus; dm_en = v.dme; im_en = v.ime; end_process = v.endp;
            dump_addr = v.dump;
            tick();
            check({tag, " status"}, 32'(status), 32'(v.e_st));
            if (v.rd_chk) begin
                check({tag, " im_out"}, 32'(im_out), 32'(v.e_im));
                check({tag, " dm_out"}, 32'(dm_out), 32'(v.e_dm));
            end
            check({tag, " dump_data"}, 32'(dump_data), 32'(v.e_dump));
            check({tag, " cycle_count"}, cycle_count, v.e_cnt);
        end

        // Out-of-range write, with end_process in the same cycle: ERR wins
        idle();
        dm_en = 1; dar_out = 16'h0100; bus_out = 16'h00EE; end_process = 1;
        tick();
        check_all("oor_write", 2'b11, 16'h5A5A, 8'h99, 8'h00, 3);
        idle();
        tick();
        check_all("err_dump", 2'b11, 16'h5A5A, 8'h99, 8'h99, 3);

        // Restart from ERR, then restart in RUN has no effect
        restart = 1;
        tick();
        check_all("err_restart", 2'b00, 16'h0000, 8'h00, 8'h00, 0);
        idle();
        load_done = 1;
        tick();
        check("rerun status", 32'(status), 32'(2'b01));
        idle();
        restart = 1; pc_out = 16'h0002; dar_out = 16'h0010;
        tick();
        check_all("run_restart", 2'b01, 16'h3333, 8'hCD, 8'h00, 1);

        // Reset during a DM write cycle: write dropped, outputs cleared
        idle();
        reset = 1; dm_en = 1; dar_out = 16'h0010; bus_out = 16'h0044; pc_out = 16'h0001;
        tick();
        check_all("mid_reset", 2'b00, 16'h0000, 8'h00, 8'h00, 0);
        reset = 0;
        idle();
        load_done = 1;
        tick();
        check("post_reset status", 32'(status), 32'(2'b01));
        idle();
        pc_out = 16'h0002; dar_out = 16'h0010;
        tick();
        check_all("post_reset read", 2'b01, 16'h3333, 8'hCD, 8'h00, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
